mem_access_stage: RTL

- MEM stage of the 5-stage NPC pipeline, between EXU and WBU.
- Latches the EX/MEM payload and issues load/store requests to the data-memory bus using a valid/ready request and a response handshake.
- Sign/zero-extends load data and presents a completed MEM/WB payload to WBU with a valid/ready handshake.
- Exports destination-register info for forwarding/hazard detection.

---
 rtl/mem_access_stage.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the NPC pipeline: holds one EX/MEM payload, runs a single data-memory
// request/response, extends load data and hands a MEM/WB payload to WBU.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc_4,
  input  logic              in_reg_wen,
  input  logic [1:0]        in_wb_sel,
  input  logic [4:0]        in_reg_waddr,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic              in_mem_ren,
  input  logic              in_mem_wen,
  input  logic [2:0]        in_funct3,
  input  logic              in_branch_taken,

  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc_4,
  output logic              out_reg_wen,
  output logic [1:0]        out_wb_sel,
  output logic [4:0]        out_reg_waddr,
  output logic [XLEN-1:0]   out_alu_out,
  output logic              out_branch_taken,
  output logic [XLEN-1:0]   out_mem_data,

  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_wen,
  output logic [XLEN-1:0]   req_wdata,
  output logic [3:0]        req_wmask,
  input  logic              resp_valid,
  input  logic [XLEN-1:0]   resp_rdata,

  output logic [4:0]        fwd_reg_waddr,
  output logic              fwd_reg_wen,
  output logic              fwd_is_load
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_accept;
  logic              w_in_is_mem;
  logic [XLEN-1:0]   w_wdata;
  logic [3:0]        w_wmask;
  logic [7:0]        w_rbyte;
  logic [15:0]       w_rhalf;
  logic [XLEN-1:0]   w_load_ext;

  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_pc_4;
  logic              r_reg_wen;
  logic [1:0]        r_wb_sel;
  logic [4:0]        r_reg_waddr;
  logic [XLEN-1:0]   r_alu_out;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [2:0]        r_funct3;
  logic              r_branch_taken;
  logic [XLEN-1:0]   r_mem_data;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_wen;
  logic [XLEN-1:0]   r_req_wdata;
  logic [3:0]        r_req_wmask;

  assign w_accept    = s_valid & s_ready;
  assign w_in_is_mem = in_mem_ren | in_mem_wen;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_in_is_mem ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        if (req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)     w_state_nxt = w_in_is_mem ? ST_REQ : ST_DONE;
        else if (m_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready       = (r_state == ST_IDLE) | ((r_state == ST_DONE) & m_ready);
    req_valid     = (r_state == ST_REQ);
    m_valid       = (r_state == ST_DONE);
    fwd_reg_waddr = (r_state != ST_IDLE) ? r_reg_waddr : 5'd0;
    fwd_reg_wen   = (r_state != ST_IDLE) & r_reg_wen;
    fwd_is_load   = r_mem_ren & ((r_state == ST_REQ) | (r_state == ST_WAIT));
  end

  // Store lanes are resolved at accept so the request stays stable while stalled.
  always_comb begin
    w_wdata = '0;
    w_wmask = '0;
    if (in_mem_wen) begin
      unique case (in_funct3[1:0])
        2'b00: begin
          w_wdata = {4{in_store_data[7:0]}};
          w_wmask = 4'b0001 << in_alu_out[1:0];
        end
        2'b01: begin
          w_wdata = {2{in_store_data[15:0]}};
          w_wmask = in_alu_out[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_wdata = in_store_data;
          w_wmask = 4'hF;
        end
      endcase
    end
  end

  always_comb begin
    unique case (r_alu_out[1:0])
      2'b00:   w_rbyte = resp_rdata[7:0];
      2'b01:   w_rbyte = resp_rdata[15:8];
      2'b10:   w_rbyte = resp_rdata[23:16];
      default: w_rbyte = resp_rdata[31:24];
    endcase
    w_rhalf = r_alu_out[1] ? resp_rdata[31:16] : resp_rdata[15:0];
    unique case (r_funct3)
      3'b000:  w_load_ext = {{24{w_rbyte[7]}}, w_rbyte};
      3'b001:  w_load_ext = {{16{w_rhalf[15]}}, w_rhalf};
      3'b100:  w_load_ext = {24'd0, w_rbyte};
      3'b101:  w_load_ext = {16'd0, w_rhalf};
      default: w_load_ext = resp_rdata;
    endcase
  end

  // NOTE: payload flops are reset because they drive outputs that must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= '0;
      r_instr        <= '0;
      r_pc_4         <= '0;
      r_reg_wen      <= 1'b0;
      r_wb_sel       <= '0;
      r_reg_waddr    <= '0;
      r_alu_out      <= '0;
      r_mem_ren      <= 1'b0;
      r_mem_wen      <= 1'b0;
      r_funct3       <= '0;
      r_branch_taken <= 1'b0;
      r_mem_data     <= '0;
      r_req_addr     <= '0;
      r_req_wen      <= 1'b0;
      r_req_wdata    <= '0;
      r_req_wmask    <= '0;
    end else if (w_accept) begin
      r_pc           <= in_pc;
      r_instr        <= in_instr;
      r_pc_4         <= in_pc_4;
      r_reg_wen      <= in_reg_wen;
      r_wb_sel       <= in_wb_sel;
      r_reg_waddr    <= in_reg_waddr;
      r_alu_out      <= in_alu_out;
      r_mem_ren      <= in_mem_ren;
      r_mem_wen      <= in_mem_wen;
      r_funct3       <= in_funct3;
      r_branch_taken <= in_branch_taken;
      r_mem_data     <= '0;
      r_req_addr     <= {in_alu_out[ADDR_W-1:2], 2'b00};
      r_req_wen      <= in_mem_wen;
      r_req_wdata    <= w_wdata;
      r_req_wmask    <= w_wmask;
    end else if ((r_state == ST_WAIT) && resp_valid && r_mem_ren && !r_mem_wen) begin
      r_mem_data     <= w_load_ext;
    end
  end

  assign out_pc           = r_pc;
  assign out_instr        = r_instr;
  assign out_pc_4         = r_pc_4;
  assign out_reg_wen      = r_reg_wen;
  assign out_wb_sel       = r_wb_sel;
  assign out_reg_waddr    = r_reg_waddr;
  assign out_alu_out      = r_alu_out;
  assign out_branch_taken = r_branch_taken;
  assign out_mem_data     = r_mem_data;
  assign req_addr         = r_req_addr;
  assign req_wen          = r_req_wen;
  assign req_wdata        = r_req_wdata;
  assign req_wmask        = r_req_wmask;

endmodule
